// File: rtl/joy_serializer_tx.sv
// joy_serializer_tx: shifts both players' latched 12-bit controls onto JOY_DATA, one bit per synchronised JOY_CLK rise.
module joy_serializer_tx #(
  parameter int SYNC_STAGES = 2,
  parameter int LEAD_CLKS = 1,
  parameter int FRAME_BITS = 24
) (
  input  logic        CLK12,
  input  logic        I_RESET,
  input  logic        JOY_CLK,
  input  logic        JOY_LOAD,
  input  logic [11:0] joystick1,
  input  logic [11:0] joystick2,
  output logic        JOY_DATA,
  output logic        frame_done,
  output logic [4:0]  bit_idx
);
  typedef enum logic [1:0] {LOAD, LEAD, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] clk_sy, load_sy;
  logic clk_h, load_h, clk_rise, load_lo, load_rel;
  logic [23:0] sr, sr_n, frame;
  logic [4:0] lead, lead_n, lead_inc, idx_n;
  logic data_n, done_n;
  assign frame = {joystick1[7], joystick1[9], joystick1[11], joystick1[10],
                  joystick2[7], joystick2[9], joystick2[11], joystick2[10],
                  joystick2[0], joystick2[1], joystick2[2], joystick2[3],
                  joystick2[4], joystick2[5], joystick2[6], joystick2[8],
                  joystick1[0], joystick1[1], joystick1[2], joystick1[3],
                  joystick1[4], joystick1[5], joystick1[6], joystick1[8]};
  assign clk_rise = clk_sy[SYNC_STAGES-1] & ~clk_h;
  assign load_lo  = ~load_sy[SYNC_STAGES-1];
  // leaving LOAD needs a real release edge, so reset alone never starts a frame
  assign load_rel = load_sy[SYNC_STAGES-1] & ~load_h;
  assign lead_inc = (lead == 5'd31) ? lead : lead + 5'd1;
  always_ff @(posedge CLK12) begin
    if (I_RESET) begin
      clk_sy     <= '0;
      clk_h      <= 1'b0;
      load_sy    <= '1;
      load_h     <= 1'b1;
      state      <= LOAD;
      sr         <= '1;
      lead       <= '0;
      JOY_DATA   <= 1'b1;
      frame_done <= 1'b0;
      bit_idx    <= 5'd31;
    end else begin
      clk_sy     <= {clk_sy[SYNC_STAGES-2:0], JOY_CLK};
      clk_h      <= clk_sy[SYNC_STAGES-1];
      load_sy    <= {load_sy[SYNC_STAGES-2:0], JOY_LOAD};
      load_h     <= load_sy[SYNC_STAGES-1];
      state      <= state_n;
      sr         <= sr_n;
      lead       <= lead_n;
      JOY_DATA   <= data_n;
      frame_done <= done_n;
      bit_idx    <= idx_n;
    end
  end
  always_comb begin
    state_n = state;
    sr_n    = sr;
    lead_n  = lead;
    idx_n   = bit_idx;
    data_n  = JOY_DATA;
    done_n  = 1'b0;
    if (load_lo) begin
      state_n = LOAD;
      sr_n    = frame;
      lead_n  = '0;
      idx_n   = 5'd31;
      data_n  = 1'b1;
    end else begin
      case (state)
        LOAD: if (load_rel) begin
          lead_n = '0;
          if (LEAD_CLKS == 0) begin
            state_n = SHIFT;
            idx_n   = '0;
            data_n  = sr[0];
          end else state_n = LEAD;
        end
        LEAD: if (clk_rise) begin
          lead_n = lead_inc;
          if (lead_inc >= 5'(LEAD_CLKS)) begin
            state_n = SHIFT;
            idx_n   = '0;
            data_n  = sr[0];
          end
        end
        SHIFT: if (clk_rise) begin
          if (bit_idx == 5'(FRAME_BITS-1)) begin
            state_n = DONE;
            done_n  = 1'b1;
            idx_n   = 5'd31;
            data_n  = 1'b1;
            sr_n    = '1;
          end else begin
            sr_n   = {1'b1, sr[23:1]};
            idx_n  = bit_idx + 5'd1;
            data_n = sr[1];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_joy_serializer_tx.sv
// tb_joy_serializer_tx: reader-style stimulus with a bit/frame scoreboard and a table-driven frame model.
module tb_joy_serializer_tx;
  logic CLK12 = 1'b0, I_RESET = 1'b1, JOY_CLK = 1'b0, JOY_LOAD = 1'b1;
  logic [11:0] joystick1 = '1, joystick2 = '1;
  logic JOY_DATA, frame_done;
  logic [4:0] bit_idx;
  int n_pass = 0, n_total = 0;
  typedef struct {logic val; int pos;} exp_t;
  exp_t bq[$];
  logic [23:0] done_q[$];
  logic rx[24];
  int map8[8] = '{8, 6, 5, 4, 3, 2, 1, 0};
  int tail4[4] = '{10, 11, 9, 7};
  exp_t mon_e;
  logic [11:0] d1, d2;
  logic [23:0] de;
  always #5 CLK12 = ~CLK12;
  joy_serializer_tx dut (
    .CLK12(CLK12), .I_RESET(I_RESET), .JOY_CLK(JOY_CLK), .JOY_LOAD(JOY_LOAD),
    .joystick1(joystick1), .joystick2(joystick2),
    .JOY_DATA(JOY_DATA), .frame_done(frame_done), .bit_idx(bit_idx)
  );
  function automatic logic model_bit(input logic [11:0] a, input logic [11:0] b, input int k);
    if (k < 8) return a[map8[k]];
    if (k < 16) return b[map8[k-8]];
    if (k < 20) return b[tail4[k-16]];
    return a[tail4[k-20]];
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge CLK12);
  endtask
  // reader samples JOY_DATA at each JOY_CLK pin rise, i.e. the value presented before that rise
  always @(posedge JOY_CLK) if (bq.size() > 0) begin
    mon_e = bq.pop_front();
    chk($sformatf("data_pos%0d", mon_e.pos), 32'(JOY_DATA), 32'(mon_e.val));
    chk($sformatf("idx_pos%0d", mon_e.pos), 32'(bit_idx),
        (mon_e.pos >= 0 && mon_e.pos < 24) ? 32'(mon_e.pos) : 32'd31);
    if (mon_e.pos >= 0 && mon_e.pos < 24) rx[mon_e.pos] = JOY_DATA;
  end
  always @(negedge CLK12) if (frame_done) begin
    chk("frame_done_expected", 32'(done_q.size() > 0), 32'd1);
    if (done_q.size() > 0) begin
      de = done_q.pop_front();
      for (int k = 0; k < 8; k++) begin
        d1[map8[k]] = rx[k];
        d2[map8[k]] = rx[k+8];
      end
      for (int k = 0; k < 4; k++) begin
        d2[tail4[k]] = rx[16+k];
        d1[tail4[k]] = rx[20+k];
      end
      chk("decode_j1", 32'(d1), 32'(de[23:12]));
      chk("decode_j2", 32'(d2), 32'(de[11:0]));
    end
  end
  task automatic run_frame(input logic [11:0] a, input logic [11:0] b, input int nrise, input bit mid);
    exp_t e;
    joystick1 = a;
    joystick2 = b;
    JOY_LOAD = 1'b0;
    cyc(8);
    JOY_LOAD = 1'b1;
    cyc(8);
    for (int i = 0; i < nrise; i++) begin
      e.val = (i == 0 || i > 24) ? 1'b1 : model_bit(a, b, (i == 0) ? 0 : i - 1);
      e.pos = i - 1;
      bq.push_back(e);
    end
    if (nrise >= 25) done_q.push_back({a, b});
    for (int i = 0; i < nrise; i++) begin
      JOY_CLK = 1'b1;
      cyc(16);
      JOY_CLK = 1'b0;
      if (mid && i == 12) joystick1 = '0;
      cyc(16);
    end
    if (nrise >= 25) begin
      cyc(2);
      chk("frame_done_seen", 32'(done_q.size()), 32'd0);
    end
  endtask
  initial begin
    cyc(2);
    chk("reset_data", 32'(JOY_DATA), 32'd1);
    chk("reset_idx", 32'(bit_idx), 32'd31);
    chk("reset_done", 32'(frame_done), 32'd0);
    I_RESET = 1'b0;
    cyc(4);
    run_frame(12'hFFE, 12'hFFF, 25, 1'b0);
    run_frame(12'h0FF, 12'hF00, 26, 1'b0);
    run_frame(12'h5A3, 12'h3C6, 10, 1'b0);
    JOY_LOAD = 1'b0;
    cyc(3);
    chk("abort_data", 32'(JOY_DATA), 32'd1);
    chk("abort_idx", 32'(bit_idx), 32'd31);
    run_frame(12'hA5C, 12'hC39, 26, 1'b0);
    run_frame(12'h7E1, 12'h1E7, 26, 1'b1);
    run_frame(12'h000, 12'h1E7, 26, 1'b0);
    run_frame(12'h123, 12'h456, 5, 1'b0);
    cyc(4);
    chk("pre_reset_data", 32'(JOY_DATA), 32'd0);
    I_RESET = 1'b1;
    cyc(1);
    chk("mid_reset_data", 32'(JOY_DATA), 32'd1);
    chk("mid_reset_idx", 32'(bit_idx), 32'd31);
    I_RESET = 1'b0;
    cyc(4);
    for (int i = 0; i < 3; i++) begin
      JOY_CLK = 1'b1;
      cyc(8);
      chk("no_load_data", 32'(JOY_DATA), 32'd1);
      chk("no_load_idx", 32'(bit_idx), 32'd31);
      JOY_CLK = 1'b0;
      cyc(8);
    end
    for (int f = 0; f < 80; f++) run_frame(12'($urandom), 12'($urandom), 26, 1'b0);
    cyc(4);
    chk("bit_queue_empty", 32'(bq.size()), 32'd0);
    chk("done_queue_empty", 32'(done_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
